mbist_bram_sched: RTL and testbench

- Parametrised successor to the flat MBIST BRAM top: a scheduler that runs up to SHN external MBIST BRAM shells.
- Shells run either sequentially, one at a time (power/IR-drop limited), or all together in parallel.
- Adds a per-shell enable mask, a start/done handshake, a sticky per-shell fail map, a per-run watchdog timeout, and an abort path.
- Sits between the test controller (TEST_H, ALG_SEL) and the shell instances, replacing the fixed OR/AND reduction.

---
 rtl/mbist_pkg.sv | 34 +++
 rtl/mbist_next_sel.sv | 45 ++++
 rtl/mbist_bram_sched.sv | 245 ++++++++++++++++++++++++
 tb/tb_mbist_bram_sched.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mbist_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mbist_pkg
// Description : Shared definitions for the MBIST BRAM shell scheduler.
//               Holds the scheduler state encoding and a clog2 helper used
//               to size the CUR_SHELL shell-index bus.
// Revision    : 1.0 - initial release
// ============================================================================
package mbist_pkg;

   // Scheduler states. The encoding is fixed so that the state value seen
   // on a debug probe matches the documented numbering.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      GAP    = 2'd2,
      FINISH = 2'd3
   } state_t;

   // Number of bits needed to represent the values 0 .. n-1.
   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = n - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mbist_next_sel.sv
`default_nettype none
// ============================================================================
// Module      : mbist_next_sel
// Description : Combinational priority encoder. Finds the lowest enabled
//               shell whose 1-based index is strictly greater than base_i.
//               Used both to pick the first shell of a sequential session
//               (base_i = 0) and the following shell after a gap.
// Ports       : en_i      - shell enable mask, bit k-1 = shell k
//               base_i    - current shell index (0 = start of session)
//               found_o   - a candidate shell exists
//               sel_o     - 1-based index of the selected shell
//               onehot_o  - selected shell as a one-hot bit mask
// Revision    : 1.0 - initial release
// ============================================================================
module mbist_next_sel
   import mbist_pkg::*;
#(
   parameter int SHN = 4
) (
   input  logic [SHN-1:0]             en_i,
   input  logic [clog2(SHN+1)-1:0]    base_i,
   output logic                       found_o,
   output logic [clog2(SHN+1)-1:0]    sel_o,
   output logic [SHN-1:0]             onehot_o
);

   localparam int CW = clog2(SHN + 1);

   // Scan from the top down so the last hit written is the lowest index.
   always_comb begin
      found_o  = 1'b0;
      sel_o    = '0;
      onehot_o = '0;
      for (int i = SHN; i >= 1; i--) begin
         if (en_i[i-1] && (CW'(i) > base_i)) begin
            found_o       = 1'b1;
            sel_o         = CW'(i);
            onehot_o      = '0;
            onehot_o[i-1] = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/mbist_bram_sched.sv
`default_nettype none
// ============================================================================
// Module      : mbist_bram_sched
// Description : Scheduler for up to SHN MBIST BRAM shells. Runs the enabled
//               shells one at a time with a one-cycle idle gap between them
//               (sequential) or all together (parallel). Keeps a sticky
//               per-shell fail map, a per-run watchdog with timeout map,
//               and supports abort by dropping TEST_H.
// Ports       : TCLK, RESET_H       - clock, synchronous active-high reset
//               TEST_H              - start level (rising edge), low aborts
//               PAR_MODE            - 1 parallel / 0 sequential
//               ALG_SEL             - algorithm select, latched at start
//               SHELL_EN            - shell enable mask, latched at start
//               SH_FAIL, SH_DONE    - per-shell status from the shells
//               SH_TEST_H           - per-shell test enable (registered)
//               SH_ALG_SEL          - latched algorithm broadcast
//               BUSY, DONE, FAIL    - session status
//               FAIL_MAP, TO_MAP    - sticky fail / watchdog-expiry maps
//               CUR_SHELL           - running shell index (sequential only)
// Revision    : 1.0 - initial release
// ============================================================================
module mbist_bram_sched
   import mbist_pkg::*;
#(
   parameter int SHN   = 4,
   parameter int ASNET = 3,
   parameter int TOW   = 20,
   parameter int TMO   = 1000000
) (
   input  logic                     TCLK,
   input  logic                     RESET_H,
   input  logic                     TEST_H,
   input  logic                     PAR_MODE,
   input  logic [ASNET:0]           ALG_SEL,
   input  logic [SHN-1:0]           SHELL_EN,
   input  logic [SHN-1:0]           SH_FAIL,
   input  logic [SHN-1:0]           SH_DONE,
   output logic [SHN-1:0]           SH_TEST_H,
   output logic [ASNET:0]           SH_ALG_SEL,
   output logic                     BUSY,
   output logic                     DONE,
   output logic                     FAIL,
   output logic [SHN-1:0]           FAIL_MAP,
   output logic [SHN-1:0]           TO_MAP,
   output logic [clog2(SHN+1)-1:0]  CUR_SHELL
);

   localparam int             CW      = clog2(SHN + 1);
   localparam logic [TOW-1:0] WD_LAST = TOW'(TMO - 1);

   state_t           state_q,   state_d;
   logic             prev_q,    prev_d;
   logic [SHN-1:0]   sh_test_q, sh_test_d;
   logic [ASNET:0]   alg_q,     alg_d;
   logic             par_q,     par_d;
   logic [SHN-1:0]   en_q,      en_d;
   logic             busy_q,    busy_d;
   logic             done_q,    done_d;
   logic [SHN-1:0]   fmap_q,    fmap_d;
   logic [SHN-1:0]   tmap_q,    tmap_d;
   logic [CW-1:0]    cur_q,     cur_d;
   logic [TOW-1:0]   wd_q,      wd_d;

   logic             start;
   logic [SHN-1:0]   running;
   logic [SHN-1:0]   sel_en;
   logic [CW-1:0]    sel_base;
   logic             sel_found;
   logic [CW-1:0]    sel_idx;
   logic [SHN-1:0]   sel_onehot;

   assign start   = TEST_H & ~prev_q;
   // Shells still running after this cycle's done flags are taken into account.
   assign running = sh_test_q & ~SH_DONE;

   // In IDLE the mask is not latched yet, so the live input feeds the encoder.
   assign sel_en   = (state_q == IDLE) ? SHELL_EN : en_q;
   assign sel_base = (state_q == IDLE) ? '0       : cur_q;

   mbist_next_sel #(
      .SHN      (SHN)
   ) u_next_sel (
      .en_i     (sel_en),
      .base_i   (sel_base),
      .found_o  (sel_found),
      .sel_o    (sel_idx),
      .onehot_o (sel_onehot)
   );

   always_comb begin
      state_d   = state_q;
      prev_d    = TEST_H;
      sh_test_d = sh_test_q;
      alg_d     = alg_q;
      par_d     = par_q;
      en_d      = en_q;
      busy_d    = busy_q;
      done_d    = done_q;
      fmap_d    = fmap_q;
      tmap_d    = tmap_q;
      cur_d     = cur_q;
      wd_d      = wd_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               alg_d  = ALG_SEL;
               par_d  = PAR_MODE;
               en_d   = SHELL_EN;
               fmap_d = '0;
               tmap_d = '0;
               wd_d   = '0;
               done_d = 1'b0;
               if (SHELL_EN == '0) begin
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  cur_d   = '0;
                  state_d = FINISH;
               end else if (PAR_MODE) begin
                  sh_test_d = SHELL_EN;
                  busy_d    = 1'b1;
                  cur_d     = '0;
                  state_d   = RUN;
               end else begin
                  sh_test_d = sel_onehot;
                  busy_d    = 1'b1;
                  cur_d     = sel_idx;
                  state_d   = RUN;
               end
            end
         end

         RUN: begin
            if (!TEST_H) begin
               sh_test_d = '0;
               busy_d    = 1'b0;
               cur_d     = '0;
               state_d   = IDLE;
            end else begin
               wd_d   = wd_q + TOW'(1);
               fmap_d = fmap_q | (SH_FAIL & sh_test_q);
               if (!par_q) begin
                  // A done seen on the last watchdog cycle still counts as done.
                  if ((SH_DONE & sh_test_q) != '0) begin
                     sh_test_d = '0;
                     state_d   = GAP;
                  end else if (wd_q == WD_LAST) begin
                     tmap_d    = tmap_q | sh_test_q;
                     fmap_d    = fmap_d | sh_test_q;
                     sh_test_d = '0;
                     state_d   = GAP;
                  end
               end else begin
                  if (running == '0) begin
                     sh_test_d = '0;
                     busy_d    = 1'b0;
                     done_d    = 1'b1;
                     state_d   = FINISH;
                  end else if (wd_q == WD_LAST) begin
                     tmap_d    = tmap_q | running;
                     fmap_d    = fmap_d | running;
                     sh_test_d = '0;
                     busy_d    = 1'b0;
                     done_d    = 1'b1;
                     state_d   = FINISH;
                  end else begin
                     sh_test_d = running;
                  end
               end
            end
         end

         GAP: begin
            if (!TEST_H) begin
               sh_test_d = '0;
               busy_d    = 1'b0;
               cur_d     = '0;
               state_d   = IDLE;
            end else if (sel_found) begin
               sh_test_d = sel_onehot;
               cur_d     = sel_idx;
               wd_d      = '0;
               state_d   = RUN;
            end else begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               cur_d   = '0;
               state_d = FINISH;
            end
         end

         FINISH: begin
            if (!TEST_H) begin
               done_d  = 1'b0;
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge TCLK) begin
      if (RESET_H) begin
         state_q   <= IDLE;
         prev_q    <= 1'b0;
         sh_test_q <= '0;
         alg_q     <= '0;
         par_q     <= 1'b0;
         en_q      <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         fmap_q    <= '0;
         tmap_q    <= '0;
         cur_q     <= '0;
         wd_q      <= '0;
      end else begin
         state_q   <= state_d;
         prev_q    <= prev_d;
         sh_test_q <= sh_test_d;
         alg_q     <= alg_d;
         par_q     <= par_d;
         en_q      <= en_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         fmap_q    <= fmap_d;
         tmap_q    <= tmap_d;
         cur_q     <= cur_d;
         wd_q      <= wd_d;
      end
   end

   assign SH_TEST_H  = sh_test_q;
   assign SH_ALG_SEL = alg_q;
   assign BUSY       = busy_q;
   assign DONE       = done_q;
   assign FAIL       = done_q & (|fmap_q);
   assign FAIL_MAP   = fmap_q;
   assign TO_MAP     = tmap_q;
   assign CUR_SHELL  = cur_q;

endmodule
`default_nettype wire

// File: tb/tb_mbist_bram_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_mbist_bram_sched
// Description : Self-checking bench for mbist_bram_sched. Behavioural shells
//               finish a programmable number of cycles after being enabled.
//               Stimulus pushes expected SH_TEST_H segments, session results,
//               BUSY-fall status and reset states into queues; a monitor
//               pops and compares them as the DUT produces each event.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mbist_bram_sched;

   typedef struct packed {
      logic [3:0] val;
      int         len;
      int         cur;
   } seg_t;

   typedef struct packed {
      logic [3:0] fmap;
      logic [3:0] tmap;
      logic       fail;
      int         lat;
      logic [3:0] alg;
   } res_t;

   typedef struct packed {
      logic       done;
      logic [3:0] fmap;
   } busy_t;

   logic       TCLK;
   logic       RESET_H;
   logic       TEST_H;
   logic       PAR_MODE;
   logic [3:0] ALG_SEL;
   logic [3:0] SHELL_EN;
   logic [3:0] SH_FAIL;
   logic [3:0] SH_DONE;
   logic [3:0] SH_TEST_H;
   logic [3:0] SH_ALG_SEL;
   logic       BUSY;
   logic       DONE;
   logic       FAIL;
   logic [3:0] FAIL_MAP;
   logic [3:0] TO_MAP;
   logic [2:0] CUR_SHELL;

   int         checks = 0;
   int         errors = 0;

   seg_t       seg_q[$];
   res_t       res_q[$];
   busy_t      busy_q[$];
   int         rst_q[$];

   int         lat [4];
   logic [3:0] fcfg;
   int         cnt [4];

   mbist_bram_sched #(
      .SHN        (4),
      .ASNET      (3),
      .TOW        (8),
      .TMO        (64)
   ) dut (
      .TCLK       (TCLK),
      .RESET_H    (RESET_H),
      .TEST_H     (TEST_H),
      .PAR_MODE   (PAR_MODE),
      .ALG_SEL    (ALG_SEL),
      .SHELL_EN   (SHELL_EN),
      .SH_FAIL    (SH_FAIL),
      .SH_DONE    (SH_DONE),
      .SH_TEST_H  (SH_TEST_H),
      .SH_ALG_SEL (SH_ALG_SEL),
      .BUSY       (BUSY),
      .DONE       (DONE),
      .FAIL       (FAIL),
      .FAIL_MAP   (FAIL_MAP),
      .TO_MAP     (TO_MAP),
      .CUR_SHELL  (CUR_SHELL)
   );

   initial TCLK = 1'b0;
   always #5 TCLK = ~TCLK;

   // Shell model: a shell enabled for L cycles raises done on its L-th cycle,
   // so SH_TEST_H stays high exactly L cycles. L = 0 means never done.
   always @(posedge TCLK) begin
      for (int j = 0; j < 4; j++)
         cnt[j] <= SH_TEST_H[j] ? cnt[j] + 1 : 0;
   end

   always_comb begin
      SH_DONE = '0;
      SH_FAIL = '0;
      for (int j = 0; j < 4; j++) begin
         SH_DONE[j] = SH_TEST_H[j] && (lat[j] != 0) && (cnt[j] >= lat[j] - 1);
         SH_FAIL[j] = SH_TEST_H[j] && fcfg[j];
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_seg(input logic [3:0] v, input int l, input int c);
      seg_t s;
      s.val = v;
      s.len = l;
      s.cur = c;
      seg_q.push_back(s);
   endtask

   task automatic push_res(input logic [3:0] fm, input logic [3:0] tm, input logic f,
                           input int l, input logic [3:0] a);
      res_t r;
      r.fmap = fm;
      r.tmap = tm;
      r.fail = f;
      r.lat  = l;
      r.alg  = a;
      res_q.push_back(r);
   endtask

   task automatic push_busy(input logic d, input logic [3:0] fm);
      busy_t b;
      b.done = d;
      b.fmap = fm;
      busy_q.push_back(b);
   endtask

   task automatic set_lat(input int l0, input int l1, input int l2, input int l3);
      lat[0] = l0;
      lat[1] = l1;
      lat[2] = l2;
      lat[3] = l3;
   endtask

   // Sequential run of four shells, each L cycles, separated by 1-cycle gaps.
   task automatic push_seq4(input int l1, input int l2, input int l3, input int l4);
      push_seg(4'b0001, l1, 1);
      push_seg(4'b0000, 1,  0);
      push_seg(4'b0010, l2, 2);
      push_seg(4'b0000, 1,  0);
      push_seg(4'b0100, l3, 3);
      push_seg(4'b0000, 1,  0);
      push_seg(4'b1000, l4, 4);
   endtask

   task automatic start(input logic par, input logic [3:0] en, input logic [3:0] alg);
      @(posedge TCLK);
      #1;
      PAR_MODE = par;
      SHELL_EN = en;
      ALG_SEL  = alg;
      TEST_H   = 1'b1;
   endtask

   task automatic finish_session(input string name);
      int n;
      n = 0;
      while (!DONE && n < 400) begin
         @(negedge TCLK);
         n++;
      end
      if (!DONE) begin
         checks++;
         errors++;
         $display("FAIL %s_done_timeout: DONE got 0 expected 1", name);
      end
      // TEST_H held high after completion must not restart a session.
      repeat (6) @(posedge TCLK);
      #1;
      TEST_H = 1'b0;
      repeat (12) @(posedge TCLK);
   endtask

   task automatic wait_sh(input logic [3:0] v, input string name);
      int n;
      n = 0;
      while (SH_TEST_H !== v && n < 200) begin
         @(negedge TCLK);
         n++;
      end
      if (SH_TEST_H !== v) begin
         checks++;
         errors++;
         $display("FAIL %s_wait: SH_TEST_H got %b expected %b", name, SH_TEST_H, v);
      end
   endtask

   // Monitor: all sampling on the falling edge.
   initial begin
      logic       test_prev;
      logic       done_prev;
      logic       busy_prev;
      logic       rst_prev;
      logic [3:0] seg_val;
      int         seg_len;
      int         seg_cur;
      int         cyc;
      int         start_cyc;
      seg_t       es;
      res_t       er;
      busy_t      eb;
      int         ev;
      test_prev = 1'b0;
      done_prev = 1'b0;
      busy_prev = 1'b0;
      rst_prev  = 1'b1;
      seg_val   = 4'b0000;
      seg_len   = 1000;
      seg_cur   = 0;
      cyc       = 0;
      start_cyc = 0;
      forever begin
         @(negedge TCLK);
         cyc++;

         if (SH_TEST_H === seg_val) begin
            seg_len++;
         end else begin
            // Short all-low intervals are inter-shell gaps; long ones are idle.
            if (seg_val != 4'b0000 || seg_len < 8) begin
               if (seg_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL seg_unexpected: got %b for %0d cycles expected none",
                           seg_val, seg_len);
               end else begin
                  es = seg_q.pop_front();
                  chk("seg_val", int'(seg_val), int'(es.val));
                  chk("seg_len", seg_len, es.len);
                  if (seg_val != 4'b0000)
                     chk("seg_cur", seg_cur, es.cur);
               end
            end
            seg_val = SH_TEST_H;
            seg_len = 1;
            seg_cur = int'(CUR_SHELL);
         end

         if (TEST_H && !test_prev)
            start_cyc = cyc;

         if (DONE && !done_prev) begin
            if (res_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL done_unexpected: DONE got 1 expected 0");
            end else begin
               er = res_q.pop_front();
               chk("fail_map",   int'(FAIL_MAP),   int'(er.fmap));
               chk("to_map",     int'(TO_MAP),     int'(er.tmap));
               chk("fail",       int'(FAIL),       int'(er.fail));
               chk("done_lat",   cyc - start_cyc,  er.lat);
               chk("sh_alg_sel", int'(SH_ALG_SEL), int'(er.alg));
            end
         end

         if (!BUSY && busy_prev) begin
            if (busy_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL busy_unexpected: BUSY fell with no session ending");
            end else begin
               eb = busy_q.pop_front();
               chk("busy_fall_done", int'(DONE),     int'(eb.done));
               chk("busy_fall_fmap", int'(FAIL_MAP), int'(eb.fmap));
            end
         end

         if (!RESET_H && rst_prev) begin
            if (rst_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rst_unexpected: reset check with no expectation");
            end else begin
               ev = rst_q.pop_front();
               chk("reset_outputs",
                   int'({SH_TEST_H, SH_ALG_SEL, BUSY, DONE, FAIL, FAIL_MAP, TO_MAP, CUR_SHELL}),
                   ev);
            end
         end

         test_prev = TEST_H;
         done_prev = DONE;
         busy_prev = BUSY;
         rst_prev  = RESET_H;
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation got stuck expected completion");
      $fatal(1, "global timeout");
   end

   initial begin
      RESET_H  = 1'b1;
      TEST_H   = 1'b0;
      PAR_MODE = 1'b0;
      ALG_SEL  = 4'h0;
      SHELL_EN = 4'h0;
      fcfg     = 4'b0000;
      set_lat(0, 0, 0, 0);
      rst_q.push_back(0);
      repeat (3) @(posedge TCLK);
      #1;
      RESET_H = 1'b0;
      repeat (12) @(posedge TCLK);

      // 1: sequential, all enabled, shell 3 fails; mid-session input changes ignored.
      set_lat(10, 10, 10, 10);
      fcfg = 4'b0100;
      push_seq4(10, 10, 10, 10);
      push_res(4'b0100, 4'b0000, 1'b1, 45, 4'h5);
      push_busy(1'b1, 4'b0100);
      start(1'b0, 4'b1111, 4'h5);
      @(posedge TCLK);
      #1;
      SHELL_EN = 4'b0000;
      PAR_MODE = 1'b1;
      ALG_SEL  = 4'hA;
      finish_session("seq_all");

      // 2: parallel, shells 1,2,4 finishing after 5, 9, 20 cycles.
      set_lat(5, 9, 0, 20);
      fcfg = 4'b0000;
      push_seg(4'b1011, 5,  0);
      push_seg(4'b1010, 4,  0);
      push_seg(4'b1000, 11, 0);
      push_res(4'b0000, 4'b0000, 1'b0, 21, 4'h3);
      push_busy(1'b1, 4'b0000);
      start(1'b1, 4'b1011, 4'h3);
      finish_session("par");

      // 3: sequential, shell 2 never finishes -> watchdog after 64 cycles.
      set_lat(10, 0, 10, 10);
      push_seq4(10, 64, 10, 10);
      push_res(4'b0010, 4'b0010, 1'b1, 99, 4'h6);
      push_busy(1'b1, 4'b0010);
      start(1'b0, 4'b1111, 4'h6);
      finish_session("seq_tmo");

      // 4: nothing enabled.
      push_res(4'b0000, 4'b0000, 1'b0, 1, 4'h9);
      start(1'b0, 4'b0000, 4'h9);
      finish_session("empty");

      // 5: abort while shell 2 runs, then restart with maps cleared.
      set_lat(10, 10, 10, 10);
      fcfg = 4'b0001;
      push_seg(4'b0001, 10, 1);
      push_seg(4'b0000, 1,  0);
      push_seg(4'b0010, 4,  2);
      push_busy(1'b0, 4'b0001);
      start(1'b0, 4'b1111, 4'h2);
      wait_sh(4'b0010, "abort");
      repeat (3) @(posedge TCLK);
      #1;
      TEST_H = 1'b0;
      repeat (12) @(posedge TCLK);
      fcfg = 4'b0000;
      push_seq4(10, 10, 10, 10);
      push_res(4'b0000, 4'b0000, 1'b0, 45, 4'h4);
      push_busy(1'b1, 4'b0000);
      start(1'b0, 4'b1111, 4'h4);
      finish_session("restart");

      // 6a: reset mid-run.
      push_seg(4'b0001, 3, 1);
      push_busy(1'b0, 4'b0000);
      rst_q.push_back(0);
      start(1'b0, 4'b1111, 4'h7);
      wait_sh(4'b0001, "reset");
      repeat (2) @(posedge TCLK);
      #1;
      RESET_H = 1'b1;
      TEST_H  = 1'b0;
      @(posedge TCLK);
      #1;
      RESET_H = 1'b0;
      repeat (12) @(posedge TCLK);

      // 6b: done coincides with the last watchdog cycle -> no timeout.
      set_lat(64, 0, 0, 0);
      push_seg(4'b0001, 64, 1);
      push_res(4'b0000, 4'b0000, 1'b0, 66, 4'h1);
      push_busy(1'b1, 4'b0000);
      start(1'b0, 4'b0001, 4'h1);
      finish_session("tie");

      // 7: parallel watchdog expiry with shell 4 stuck.
      set_lat(5, 9, 0, 0);
      push_seg(4'b1011, 5,  0);
      push_seg(4'b1010, 4,  0);
      push_seg(4'b1000, 55, 0);
      push_res(4'b1000, 4'b1000, 1'b1, 65, 4'hC);
      push_busy(1'b1, 4'b1000);
      start(1'b1, 4'b1011, 4'hC);
      finish_session("par_tmo");

      repeat (5) @(posedge TCLK);
      chk("seg_q_left",  seg_q.size(),  0);
      chk("res_q_left",  res_q.size(),  0);
      chk("busy_q_left", busy_q.size(), 0);
      chk("rst_q_left",  rst_q.size(),  0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
